// File: rtl/buffer_unshift.sv
// rtl/buffer_unshift.sv - parallel-in / serial-out word buffer drained over a valid/ready stream
// One packed NUM-word vector is loaded, then presented one WIDTH-bit word per accepted cycle.
module buffer_unshift #(
  parameter int NUM       = 4,
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*NUM-1:0] din,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [WIDTH*NUM-1:0] buff;
  logic [WIDTH*NUM-1:0] buff_shifted;
  logic [CW-1:0]        cnt;
  logic                 accept;

  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign out_last  = (state == SHIFT) && (cnt == CNT_LAST);
  assign accept    = out_valid && out_ready;
  // Final-word accept frees the buffer in the same cycle for a bubble-free reload.
  assign in_ready  = !rst && ((state == IDLE) || (accept && out_last));

  generate
    if (MSB_FIRST) begin : g_out_msb
      assign dout = buff[WIDTH*NUM-1 -: WIDTH];
    end else begin : g_out_lsb
      assign dout = buff[WIDTH-1:0];
    end

    if (NUM == 1) begin : g_shift_none
      assign buff_shifted = '0;
    end else if (MSB_FIRST) begin : g_shift_up
      assign buff_shifted = {buff[WIDTH*(NUM-1)-1:0], {WIDTH{1'b0}}};
    end else begin : g_shift_down
      assign buff_shifted = {{WIDTH{1'b0}}, buff[WIDTH*NUM-1:WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      buff  <= '0;
      cnt   <= '0;
    end else if (in_valid && in_ready) begin
      state <= SHIFT;
      buff  <= din;
      cnt   <= '0;
    end else if (accept) begin
      if (out_last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        buff <= buff_shifted;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buffer_unshift.sv
// tb/tb_buffer_unshift.sv - bench for buffer_unshift against a queue-based word model
// Three instances: NUM=4 MSB-first, NUM=4 LSB-first, NUM=1 WIDTH=8.
module tb_buffer_unshift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, in_valid, out_ready;
  logic [63:0] din4;
  logic [7:0]  din1;
  logic        ov [3];
  logic        ir [3];
  logic        ol [3];
  logic        bz [3];
  logic [15:0] dq0, dq1;
  logic [7:0]  dq2;

  buffer_unshift #(.NUM(4), .WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[0]), .din(din4),
    .out_valid(ov[0]), .out_ready(out_ready), .dout(dq0), .out_last(ol[0]), .busy(bz[0]));

  buffer_unshift #(.NUM(4), .WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[1]), .din(din4),
    .out_valid(ov[1]), .out_ready(out_ready), .dout(dq1), .out_last(ol[1]), .busy(bz[1]));

  buffer_unshift #(.NUM(1), .WIDTH(8), .MSB_FIRST(1'b1)) u_one (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[2]), .din(din1),
    .out_valid(ov[2]), .out_ready(out_ready), .dout(dq2), .out_last(ol[2]), .busy(bz[2]));

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          started = 1'b0;
  logic [15:0] mq [3][$];
  bit          zf [3];
  logic [15:0] logw [3][$];
  bit          logl [3][$];
  int          logc [3][$];
  int          last_load [3];
  bit          ir_en = 1'b0;
  int          irc = 0;

  function automatic int num_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int width_of(input int k);
    return (k == 2) ? 8 : 16;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 1);
  endfunction

  function automatic logic [15:0] dout_of(input int k);
    return (k == 0) ? dq0 : (k == 1) ? dq1 : {8'h00, dq2};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: each instance holds the queue of words still to be emitted, in emission order.
  always @(posedge clk) begin : model
    int sz;
    int idx;
    bit v;
    bit irx;
    logic [63:0] d;
    if (rst) started = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sz  = mq[k].size();
      v   = (sz > 0);
      irx = !rst && (sz == 0 || (out_ready && sz == 1));
      if (rst || clr) begin
        mq[k].delete();
        zf[k] = 1'b1;
      end else begin
        if (ov[k] && out_ready) begin
          logw[k].push_back(dout_of(k));
          logl[k].push_back(ol[k]);
          logc[k].push_back(cyc);
        end
        if (v && out_ready) void'(mq[k].pop_front());
        if (in_valid && irx) begin
          d = (k == 2) ? {56'h0, din1} : din4;
          mq[k].delete();
          for (int i = 0; i < num_of(k); i++) begin
            idx = msb_of(k) ? num_of(k) - 1 - i : i;
            mq[k].push_back(16'((d >> (idx * width_of(k))) & ((64'h1 << width_of(k)) - 1)));
          end
          zf[k] = 1'b0;
          last_load[k] = cyc;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    int sz;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        sz = mq[k].size();
        chk($sformatf("out_valid[%0d]", k), ov[k], sz > 0);
        chk($sformatf("busy[%0d]", k), bz[k], sz > 0);
        chk($sformatf("out_last[%0d]", k), ol[k], sz == 1);
        chk($sformatf("in_ready[%0d]", k), ir[k], !rst && (sz == 0 || (out_ready && sz == 1)));
        if (sz > 0) chk($sformatf("dout[%0d]", k), dout_of(k), mq[k][0]);
        else if (zf[k]) chk($sformatf("dout_zero[%0d]", k), dout_of(k), 16'h0);
      end
      if (ir_en) irc += int'(ir[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    for (int k = 0; k < 3; k++) begin
      logw[k].delete();
      logl[k].delete();
      logc[k].delete();
    end
  endtask

  task automatic check_log(input int k, input string nm, input logic [15:0] e [8], input int n,
                           input logic [7:0] lm, input bit consec);
    chk({nm, "_count"}, logw[k].size(), n);
    for (int i = 0; i < n && i < logw[k].size(); i++) begin
      chk($sformatf("%s_word%0d", nm, i), logw[k][i], e[i]);
      chk($sformatf("%s_last%0d", nm, i), logl[k][i], lm[i]);
      if (consec && i > 0) chk($sformatf("%s_cycle%0d", nm, i), logc[k][i], logc[k][0] + i);
    end
  endtask

  task automatic send1(input logic [7:0] data);
    bit hs;
    int g;
    hs = 1'b0;
    g = 0;
    din1 = data;
    in_valid = 1'b1;
    while (!hs && g < 50) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = ir[2];
      @(posedge clk);
      #1;
      g++;
    end
    if (!hs) chk("t6_load_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] e [8];
    logic [6:0]  pat;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din4 = '0; din1 = '0;
    repeat (2) step();

    // Reset released, then reset asserted mid-drain for three clocks
    rst = 1'b0;
    @(negedge clk);
    chk("t1_in_ready_after_rst", ir[0], 1'b1);
    step();
    in_valid = 1'b1; din4 = 64'h4444_3333_2222_1111; din1 = 8'h11; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("t1_out_valid_rst", ov[0], 1'b0);
    chk("t1_busy_rst", bz[0], 1'b0);
    chk("t1_dout_rst", dq0, 16'h0);
    chk("t1_in_ready_rst", ir[0], 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_in_ready_first", ir[0], 1'b1);
    step();

    // Straight drain, both word orders
    idle_drain();
    in_valid = 1'b1; din4 = 64'h4444_3333_2222_1111; din1 = 8'h5A;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    e = '{16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h0};
    check_log(0, "t2_msb", e, 4, 8'b0000_1000, 1'b1);
    if (logc[0].size() > 0) chk("t2_latency", logc[0][0], last_load[0] + 1);
    e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
    check_log(1, "t2_lsb", e, 4, 8'b0000_1000, 1'b1);

    // Backpressure pattern 1,0,0,1,0,1,1
    idle_drain();
    pat = 7'b1101001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    e = '{16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h0};
    check_log(0, "t3_msb", e, 4, 8'b0000_1000, 1'b0);

    // Back-to-back reload with in_valid held
    idle_drain();
    in_valid = 1'b1; din4 = 64'h4444_3333_2222_1111;
    step();
    din4 = 64'h8888_7777_6666_5555;
    irc = 0;
    ir_en = 1'b1;
    repeat (4) step();
    ir_en = 1'b0;
    in_valid = 1'b0;
    repeat (6) step();
    chk("t4_in_ready_pulses", irc, 1);
    e = '{16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h8888, 16'h7777, 16'h6666, 16'h5555};
    check_log(0, "t4_msb", e, 8, 8'b1000_1000, 1'b1);

    // Abort after the second accepted word
    idle_drain();
    in_valid = 1'b1; din4 = 64'h4444_3333_2222_1111;
    step();
    in_valid = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("t5_out_valid_clr", ov[0], 1'b0);
    chk("t5_busy_clr", bz[0], 1'b0);
    step();
    in_valid = 1'b1; din4 = 64'hDDDD_CCCC_BBBB_AAAA;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    e = '{16'h4444, 16'h3333, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h0, 16'h0};
    check_log(0, "t5_msb", e, 6, 8'b0010_0000, 1'b0);
    e = '{16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0, 16'h0};
    check_log(1, "t5_lsb", e, 6, 8'b0010_0000, 1'b0);

    // Single-word instance with toggling out_ready
    idle_drain();
    send1(8'h5A);
    send1(8'hA5);
    repeat (20) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    e = '{16'h005A, 16'h00A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    check_log(2, "t6_one", e, 2, 8'b0000_0011, 1'b0);

    // Random traffic with occasional abort and reset
    repeat (400) begin
      rst       = ($urandom_range(0, 199) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      din4      = {$urandom, $urandom};
      din1      = 8'($urandom);
      step();
    end
    rst = 1'b0;
    idle_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
